// File: rtl/icache_linefill_ctrl_pkg.sv
// Shared types and geometry for the icache refill (linefill) path.
// Beat/line geometry is fixed here so the line buffer and the controller agree.
package toy_pack;

  localparam int ICACHE_INDEX_WIDTH     = 6;
  localparam int ICACHE_TAG_WIDTH       = 20;
  localparam int ICACHE_REQ_TXNID_WIDTH = 5;
  localparam int DATA_WIDTH             = 64;
  localparam int BEAT_NUM               = 4;
  localparam int LINE_WIDTH             = DATA_WIDTH * BEAT_NUM;

  typedef enum logic [1:0] {
    LF_IDLE,
    LF_COLLECT,
    LF_WRITE,
    LF_DONE
  } linefill_state_t;

  typedef struct packed {
    logic [ICACHE_REQ_TXNID_WIDTH-1:0] txnid;
    logic [DATA_WIDTH-1:0]             data;
    logic                              last;
  } rxdat_pld_t;

endpackage

// File: rtl/icache_linefill_buf.sv
// Refill line buffer: one register per beat slot, written at the current beat count.
// clr discards any partial line and rewinds the count to slot 0.
module icache_linefill_buf
  import toy_pack::*;
#(
  parameter int DW    = DATA_WIDTH,
  parameter int BEATS = BEAT_NUM,
  parameter int CNT_W = $clog2(BEATS) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [DW-1:0]              wr_data,
  output logic [BEATS-1:0][DW-1:0]   line,
  output logic [CNT_W-1:0]           beat_cnt,
  output logic                       full
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BEATS);

  assign full = (beat_cnt == FULL_CNT);

  // Count saturates at BEATS; it only rewinds through clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                beat_cnt <= '0;
    else if (clr)              beat_cnt <= '0;
    else if (wr_en && !full)   beat_cnt <= beat_cnt + 1'b1;
  end

  for (genvar s = 0; s < BEATS; s++) begin : g_slot
    logic slot_we;
    assign slot_we = wr_en && !full && (beat_cnt == CNT_W'(s));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       line[s] <= '0;
      else if (clr)     line[s] <= '0;
      else if (slot_we) line[s] <= wr_data;
    end
  end

endmodule

// File: rtl/icache_linefill_ctrl.sv
// Refill response controller: collects beats for one MSHR entry, writes the
// assembled line and tag into the RAMs, then pulses that entry's linefill_done.
module icache_linefill_ctrl
  import toy_pack::*;
#(
  parameter int MSHR_ENTRY_NUM = 8,
  parameter int TXNID_WIDTH    = ICACHE_REQ_TXNID_WIDTH,
  parameter int INDEX_WIDTH    = ICACHE_INDEX_WIDTH,
  parameter int TAG_WIDTH      = ICACHE_TAG_WIDTH
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       rxdat_vld,
  output logic                                       rxdat_rdy,
  input  logic [TXNID_WIDTH-1:0]                     rxdat_txnid,
  input  logic [DATA_WIDTH-1:0]                      rxdat_data,
  input  logic                                       rxdat_last,
  input  logic [MSHR_ENTRY_NUM-1:0]                  entry_valid,
  input  logic [MSHR_ENTRY_NUM-1:0][INDEX_WIDTH-1:0] entry_index,
  input  logic [MSHR_ENTRY_NUM-1:0][TAG_WIDTH-1:0]   entry_tag,
  input  logic [MSHR_ENTRY_NUM-1:0]                  entry_way,
  output logic                                       dataram_wr_vld,
  input  logic                                       dataram_wr_rdy,
  output logic [INDEX_WIDTH-1:0]                     dataram_wr_index,
  output logic                                       dataram_wr_way,
  output logic [LINE_WIDTH-1:0]                      dataram_wr_data,
  output logic                                       tagram_wr_en,
  output logic [TAG_WIDTH-1:0]                       tagram_wr_tag,
  output logic [MSHR_ENTRY_NUM-1:0]                  linefill_done,
  output logic                                       protocol_err
);

  localparam int ENTRY_ID_W = (MSHR_ENTRY_NUM > 1) ? $clog2(MSHR_ENTRY_NUM) : 1;
  localparam int CNT_W      = $clog2(BEAT_NUM) + 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(BEAT_NUM - 1);

  linefill_state_t                 state, state_nxt;
  logic [ENTRY_ID_W-1:0]           rx_id, id_q;
  logic [INDEX_WIDTH-1:0]          index_q;
  logic [TAG_WIDTH-1:0]            tag_q;
  logic                            way_q;
  logic                            err_q, err_nxt;
  logic                            buf_wr, buf_clr, latch_entry;
  logic [CNT_W-1:0]                beat_cnt;
  logic                            buf_full;
  logic [BEAT_NUM-1:0][DATA_WIDTH-1:0] line;
  logic                            unused_sig;

  assign rx_id      = rxdat_txnid[ENTRY_ID_W-1:0];
  assign unused_sig = ^{rxdat_txnid, buf_full};

  icache_linefill_buf #(
    .DW    (DATA_WIDTH),
    .BEATS (BEAT_NUM),
    .CNT_W (CNT_W)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (buf_clr),
    .wr_en    (buf_wr),
    .wr_data  (rxdat_data),
    .line     (line),
    .beat_cnt (beat_cnt),
    .full     (buf_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LF_IDLE;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= err_nxt;
    end
  end

  // Entry attributes are captured once so MSHR-side changes cannot disturb an in-flight line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q    <= '0;
      index_q <= '0;
      tag_q   <= '0;
      way_q   <= 1'b0;
    end else if (latch_entry) begin
      id_q    <= rx_id;
      index_q <= entry_index[rx_id];
      tag_q   <= entry_tag[rx_id];
      way_q   <= entry_way[rx_id];
    end
  end

  always_comb begin
    state_nxt      = state;
    rxdat_rdy      = 1'b0;
    buf_wr         = 1'b0;
    buf_clr        = 1'b0;
    latch_entry    = 1'b0;
    err_nxt        = 1'b0;
    dataram_wr_vld = 1'b0;
    linefill_done  = '0;
    case (state)
      LF_IDLE: begin
        rxdat_rdy = 1'b1;
        if (rxdat_vld) begin
          if (!entry_valid[rx_id]) begin
            err_nxt = 1'b1;
          end else if (BEAT_NUM == 1) begin
            buf_wr      = 1'b1;
            latch_entry = 1'b1;
            err_nxt     = !rxdat_last;
            state_nxt   = LF_WRITE;
          end else if (rxdat_last) begin
            // Line ended on its first beat: nothing stored, nothing to abandon.
            err_nxt = 1'b1;
          end else begin
            buf_wr      = 1'b1;
            latch_entry = 1'b1;
            state_nxt   = LF_COLLECT;
          end
        end
      end
      LF_COLLECT: begin
        rxdat_rdy = 1'b1;
        if (rxdat_vld) begin
          if (rx_id != id_q) begin
            err_nxt = 1'b1;
          end else if (beat_cnt == LAST_SLOT) begin
            buf_wr    = 1'b1;
            err_nxt   = !rxdat_last;
            state_nxt = LF_WRITE;
          end else if (rxdat_last) begin
            err_nxt   = 1'b1;
            buf_clr   = 1'b1;
            state_nxt = LF_IDLE;
          end else begin
            buf_wr = 1'b1;
          end
        end
      end
      LF_WRITE: begin
        dataram_wr_vld = 1'b1;
        if (dataram_wr_rdy) state_nxt = LF_DONE;
      end
      LF_DONE: begin
        linefill_done[id_q] = 1'b1;
        buf_clr             = 1'b1;
        state_nxt           = LF_IDLE;
      end
      default: state_nxt = LF_IDLE;
    endcase
  end

  assign tagram_wr_en     = dataram_wr_vld & dataram_wr_rdy;
  assign dataram_wr_index = index_q;
  assign dataram_wr_way   = way_q;
  assign dataram_wr_data  = line;
  assign tagram_wr_tag    = tag_q;
  assign protocol_err     = err_q;

endmodule

// File: tb/tb_icache_linefill_ctrl.sv
// Directed bench for icache_linefill_ctrl: normal fill, backpressure, illegal beats, reset.
module tb_icache_linefill_ctrl;
  import toy_pack::*;

  localparam int N  = 8;
  localparam int IW = 6;
  localparam int TW = 20;
  localparam int XW = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                    rxdat_vld, rxdat_rdy, rxdat_last;
  logic [XW-1:0]           rxdat_txnid;
  logic [DATA_WIDTH-1:0]   rxdat_data;
  logic [N-1:0]            entry_valid;
  logic [N-1:0][IW-1:0]    entry_index;
  logic [N-1:0][TW-1:0]    entry_tag;
  logic [N-1:0]            entry_way;
  logic                    dataram_wr_vld, dataram_wr_rdy;
  logic [IW-1:0]           dataram_wr_index;
  logic                    dataram_wr_way;
  logic [LINE_WIDTH-1:0]   dataram_wr_data;
  logic                    tagram_wr_en;
  logic [TW-1:0]           tagram_wr_tag;
  logic [N-1:0]            linefill_done;
  logic                    protocol_err;

  int vec = 0;
  int errs = 0;
  logic [LINE_WIDTH-1:0] exp_line;

  icache_linefill_ctrl #(
    .MSHR_ENTRY_NUM (N),
    .TXNID_WIDTH    (XW),
    .INDEX_WIDTH    (IW),
    .TAG_WIDTH      (TW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rxdat_vld        (rxdat_vld),
    .rxdat_rdy        (rxdat_rdy),
    .rxdat_txnid      (rxdat_txnid),
    .rxdat_data       (rxdat_data),
    .rxdat_last       (rxdat_last),
    .entry_valid      (entry_valid),
    .entry_index      (entry_index),
    .entry_tag        (entry_tag),
    .entry_way        (entry_way),
    .dataram_wr_vld   (dataram_wr_vld),
    .dataram_wr_rdy   (dataram_wr_rdy),
    .dataram_wr_index (dataram_wr_index),
    .dataram_wr_way   (dataram_wr_way),
    .dataram_wr_data  (dataram_wr_data),
    .tagram_wr_en     (tagram_wr_en),
    .tagram_wr_tag    (tagram_wr_tag),
    .linefill_done    (linefill_done),
    .protocol_err     (protocol_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pat(input int k, input logic [63:0] salt);
    return (64'h1111111111111111 * 64'(k + 1)) ^ salt;
  endfunction

  task automatic send_beat(input int id, input logic [63:0] d, input logic last);
    rxdat_vld   = 1'b1;
    rxdat_txnid = XW'(id);
    rxdat_data  = d;
    rxdat_last  = last;
    tick();
    rxdat_vld  = 1'b0;
    rxdat_last = 1'b0;
  endtask

  // Full 4-beat line; exp_line is the bench's own assembly of the beats.
  task automatic send_line(input int id, input logic [63:0] salt, input logic last_on_final);
    for (int k = 0; k < 4; k++) begin
      exp_line[k*64 +: 64] = pat(k, salt);
      send_beat(id, pat(k, salt), (k == 3) ? last_on_final : 1'b0);
    end
  endtask

  task automatic load_entries();
    for (int e = 0; e < N; e++) begin
      entry_valid[e] = 1'b1;
      entry_index[e] = IW'(e * 5 + 1);
      entry_tag[e]   = TW'(32'hA0000 + e);
      entry_way[e]   = e[0];
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rxdat_vld = 1'b0; rxdat_last = 1'b0; rxdat_txnid = '0; rxdat_data = '0;
    dataram_wr_rdy = 1'b1;
    load_entries();
    #12;
    vec++; if (rxdat_rdy !== 1'b1) begin errs++; $display("FAIL reset_rdy got=%b exp=1", rxdat_rdy); end
    vec++; if (dataram_wr_vld !== 1'b0) begin errs++; $display("FAIL reset_wr_vld got=%b exp=0", dataram_wr_vld); end
    vec++; if (linefill_done !== 8'h00) begin errs++; $display("FAIL reset_done got=%b exp=0", linefill_done); end
    vec++; if (protocol_err !== 1'b0) begin errs++; $display("FAIL reset_err got=%b exp=0", protocol_err); end
    vec++; if (tagram_wr_en !== 1'b0) begin errs++; $display("FAIL reset_tag_en got=%b exp=0", tagram_wr_en); end
    vec++; if (dataram_wr_data !== '0) begin errs++; $display("FAIL reset_data got=%h exp=0", dataram_wr_data); end
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [LINE_WIDTH-1:0] lit;
    lit = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
    send_line(3, 64'h0, 1'b1);
    vec++; if (dataram_wr_vld !== 1'b1) begin errs++; $display("FAIL basic_wr_vld got=%b exp=1", dataram_wr_vld); end
    vec++; if (rxdat_rdy !== 1'b0) begin errs++; $display("FAIL basic_rdy_write got=%b exp=0", rxdat_rdy); end
    vec++; if (dataram_wr_data !== lit) begin errs++; $display("FAIL basic_data got=%h exp=%h", dataram_wr_data, lit); end
    vec++; if (dataram_wr_index !== 6'd16) begin errs++; $display("FAIL basic_index got=%0d exp=16", dataram_wr_index); end
    vec++; if (dataram_wr_way !== 1'b1) begin errs++; $display("FAIL basic_way got=%b exp=1", dataram_wr_way); end
    vec++; if (tagram_wr_en !== 1'b1) begin errs++; $display("FAIL basic_tag_en got=%b exp=1", tagram_wr_en); end
    vec++; if (tagram_wr_tag !== 20'hA0003) begin errs++; $display("FAIL basic_tag got=%h exp=a0003", tagram_wr_tag); end
    vec++; if (linefill_done !== 8'h00) begin errs++; $display("FAIL basic_done_early got=%b exp=0", linefill_done); end
    vec++; if (protocol_err !== 1'b0) begin errs++; $display("FAIL basic_err got=%b exp=0", protocol_err); end
    tick();
    vec++; if (linefill_done !== 8'b0000_1000) begin errs++; $display("FAIL basic_done got=%b exp=00001000", linefill_done); end
    vec++; if (dataram_wr_vld !== 1'b0) begin errs++; $display("FAIL basic_wr_vld_off got=%b exp=0", dataram_wr_vld); end
    vec++; if (rxdat_rdy !== 1'b0) begin errs++; $display("FAIL basic_rdy_done got=%b exp=0", rxdat_rdy); end
    tick();
    vec++; if (linefill_done !== 8'h00) begin errs++; $display("FAIL basic_done_1cyc got=%b exp=0", linefill_done); end
    vec++; if (rxdat_rdy !== 1'b1) begin errs++; $display("FAIL basic_rdy_idle got=%b exp=1", rxdat_rdy); end
  endtask

  task automatic test_backpressure();
    dataram_wr_rdy = 1'b0;
    exp_line[63:0] = pat(0, 64'hF0F0);
    send_beat(3, pat(0, 64'hF0F0), 1'b0);
    // Entry attributes move after the first beat; the line must keep the original ones.
    entry_index[3] = 6'h3F; entry_tag[3] = 20'h12345; entry_way[3] = 1'b0;
    for (int k = 1; k < 4; k++) begin
      exp_line[k*64 +: 64] = pat(k, 64'hF0F0);
      send_beat(3, pat(k, 64'hF0F0), k == 3);
    end
    for (int i = 0; i < 5; i++) begin
      vec++; if (dataram_wr_vld !== 1'b1) begin errs++; $display("FAIL bp_wr_vld cyc=%0d got=%b exp=1", i, dataram_wr_vld); end
      vec++; if (dataram_wr_data !== exp_line) begin errs++; $display("FAIL bp_data cyc=%0d got=%h exp=%h", i, dataram_wr_data, exp_line); end
      vec++; if (dataram_wr_index !== 6'd16) begin errs++; $display("FAIL bp_index cyc=%0d got=%0d exp=16", i, dataram_wr_index); end
      vec++; if (rxdat_rdy !== 1'b0) begin errs++; $display("FAIL bp_rdy cyc=%0d got=%b exp=0", i, rxdat_rdy); end
      vec++; if (tagram_wr_en !== 1'b0) begin errs++; $display("FAIL bp_tag_en cyc=%0d got=%b exp=0", i, tagram_wr_en); end
      vec++; if (linefill_done !== 8'h00) begin errs++; $display("FAIL bp_done cyc=%0d got=%b exp=0", i, linefill_done); end
      tick();
    end
    dataram_wr_rdy = 1'b1;
    #1;
    vec++; if (tagram_wr_en !== 1'b1) begin errs++; $display("FAIL bp_tag_en_hs got=%b exp=1", tagram_wr_en); end
    vec++; if (tagram_wr_tag !== 20'hA0003) begin errs++; $display("FAIL bp_tag got=%h exp=a0003", tagram_wr_tag); end
    vec++; if (dataram_wr_way !== 1'b1) begin errs++; $display("FAIL bp_way got=%b exp=1", dataram_wr_way); end
    tick();
    vec++; if (linefill_done !== 8'b0000_1000) begin errs++; $display("FAIL bp_done_hs got=%b exp=00001000", linefill_done); end
    tick();
    load_entries();
  endtask

  task automatic test_interleave();
    exp_line[63:0]    = pat(0, 64'hAB00);
    exp_line[127:64]  = pat(1, 64'hAB00);
    exp_line[191:128] = pat(2, 64'hAB00);
    exp_line[255:192] = pat(3, 64'hAB00);
    send_beat(2, pat(0, 64'hAB00), 1'b0);
    send_beat(2, pat(1, 64'hAB00), 1'b0);
    send_beat(5, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
    vec++; if (protocol_err !== 1'b1) begin errs++; $display("FAIL il_err got=%b exp=1", protocol_err); end
    vec++; if (rxdat_rdy !== 1'b1) begin errs++; $display("FAIL il_rdy got=%b exp=1", rxdat_rdy); end
    send_beat(2, pat(2, 64'hAB00), 1'b0);
    vec++; if (protocol_err !== 1'b0) begin errs++; $display("FAIL il_err_pulse got=%b exp=0", protocol_err); end
    send_beat(2, pat(3, 64'hAB00), 1'b1);
    vec++; if (dataram_wr_data !== exp_line) begin errs++; $display("FAIL il_data got=%h exp=%h", dataram_wr_data, exp_line); end
    vec++; if (dataram_wr_index !== 6'd11) begin errs++; $display("FAIL il_index got=%0d exp=11", dataram_wr_index); end
    vec++; if (dataram_wr_way !== 1'b0) begin errs++; $display("FAIL il_way got=%b exp=0", dataram_wr_way); end
    tick();
    vec++; if (linefill_done !== 8'b0000_0100) begin errs++; $display("FAIL il_done got=%b exp=00000100", linefill_done); end
    tick();
  endtask

  task automatic test_invalid_entry();
    entry_valid[6] = 1'b0;
    send_beat(6, 64'h6666, 1'b0);
    vec++; if (protocol_err !== 1'b1) begin errs++; $display("FAIL inv_err got=%b exp=1", protocol_err); end
    vec++; if (rxdat_rdy !== 1'b1) begin errs++; $display("FAIL inv_rdy got=%b exp=1", rxdat_rdy); end
    tick();
    vec++; if (protocol_err !== 1'b0) begin errs++; $display("FAIL inv_err_pulse got=%b exp=0", protocol_err); end
    entry_valid[6] = 1'b1;
    send_line(1, 64'h0101, 1'b1);
    vec++; if (dataram_wr_data !== exp_line) begin errs++; $display("FAIL inv_next_data got=%h exp=%h", dataram_wr_data, exp_line); end
    vec++; if (dataram_wr_index !== 6'd6) begin errs++; $display("FAIL inv_next_index got=%0d exp=6", dataram_wr_index); end
    tick();
    vec++; if (linefill_done !== 8'b0000_0010) begin errs++; $display("FAIL inv_next_done got=%b exp=00000010", linefill_done); end
    tick();
  endtask

  task automatic test_early_last();
    send_beat(4, pat(0, 64'h4400), 1'b0);
    send_beat(4, pat(1, 64'h4400), 1'b1);
    vec++; if (protocol_err !== 1'b1) begin errs++; $display("FAIL el_err got=%b exp=1", protocol_err); end
    vec++; if (rxdat_rdy !== 1'b1) begin errs++; $display("FAIL el_rdy got=%b exp=1", rxdat_rdy); end
    for (int i = 0; i < 3; i++) begin
      vec++; if (dataram_wr_vld !== 1'b0) begin errs++; $display("FAIL el_no_write cyc=%0d got=%b exp=0", i, dataram_wr_vld); end
      vec++; if (linefill_done !== 8'h00) begin errs++; $display("FAIL el_no_done cyc=%0d got=%b exp=0", i, linefill_done); end
      tick();
    end
    send_line(4, 64'h5A5A, 1'b1);
    vec++; if (dataram_wr_data !== exp_line) begin errs++; $display("FAIL el_next_data got=%h exp=%h", dataram_wr_data, exp_line); end
    tick();
    vec++; if (linefill_done !== 8'b0001_0000) begin errs++; $display("FAIL el_next_done got=%b exp=00010000", linefill_done); end
    tick();
  endtask

  task automatic test_final_no_last();
    send_line(7, 64'h7777, 1'b0);
    vec++; if (protocol_err !== 1'b1) begin errs++; $display("FAIL nl_err got=%b exp=1", protocol_err); end
    vec++; if (dataram_wr_vld !== 1'b1) begin errs++; $display("FAIL nl_wr_vld got=%b exp=1", dataram_wr_vld); end
    vec++; if (dataram_wr_data !== exp_line) begin errs++; $display("FAIL nl_data got=%h exp=%h", dataram_wr_data, exp_line); end
    tick();
    vec++; if (linefill_done !== 8'b1000_0000) begin errs++; $display("FAIL nl_done got=%b exp=10000000", linefill_done); end
    vec++; if (protocol_err !== 1'b0) begin errs++; $display("FAIL nl_err_pulse got=%b exp=0", protocol_err); end
    tick();
  endtask

  task automatic test_reset_midline();
    send_beat(0, 64'hCAFE_0000_0000_0001, 1'b0);
    send_beat(0, 64'hCAFE_0000_0000_0002, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    vec++; if (rxdat_rdy !== 1'b1) begin errs++; $display("FAIL rm_rdy got=%b exp=1", rxdat_rdy); end
    vec++; if (dataram_wr_data !== '0) begin errs++; $display("FAIL rm_data got=%h exp=0", dataram_wr_data); end
    vec++; if (dataram_wr_index !== 6'd0) begin errs++; $display("FAIL rm_index got=%0d exp=0", dataram_wr_index); end
    vec++; if (linefill_done !== 8'h00) begin errs++; $display("FAIL rm_done got=%b exp=0", linefill_done); end
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
    send_line(0, 64'h0F0F, 1'b1);
    vec++; if (dataram_wr_data !== exp_line) begin errs++; $display("FAIL rm_next_data got=%h exp=%h", dataram_wr_data, exp_line); end
    vec++; if (dataram_wr_index !== 6'd1) begin errs++; $display("FAIL rm_next_index got=%0d exp=1", dataram_wr_index); end
    tick();
    vec++; if (linefill_done !== 8'b0000_0001) begin errs++; $display("FAIL rm_next_done got=%b exp=00000001", linefill_done); end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_interleave();
    test_invalid_entry();
    test_early_last();
    test_final_no_last();
    test_reset_midline();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
